// File: rtl/count_down_timer_pkg.sv
// Shared definitions for the count-down timer: state encoding and the default
// count width / ceiling that the timer shares with the count-to-100 prescaler.
package count_down_timer_pkg;

   localparam int DefaultWidth    = 7;
   localparam int DefaultMaxCount = 99;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } timerState_e;

endpackage

// File: rtl/count_down_timer_ctrl_fsm.sv
// Control FSM for the count-down timer. Resolves the per-edge command priority
// (Load > Stop > Start > Ack > Tick), tells the datapath when to load or
// decrement, and registers the Running/Expired/Done status outputs.
module timer_ctrl_fsm
   import count_down_timer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic Load,
   input  logic Start,
   input  logic Stop,
   input  logic Ack,
   input  logic Tick,
   input  logic CountIsOne,
   input  logic CountIsZero,
   output logic DecEn,
   output logic LoadEn,
   output logic Running,
   output logic Expired,
   output logic Done
);

   timerState_e state;
   timerState_e nextState;
   logic        nextDone;

   // Next-state and datapath-enable decode for the current state and commands.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // it unassigned; otherwise synthesis would infer latches.
      nextState = state;
      DecEn     = 1'b0;
      LoadEn    = 1'b0;
      nextDone  = 1'b0;
      unique case (state)
         IDLE: begin
            if (Load) begin
               LoadEn = 1'b1;
            end else if (Stop) begin
               nextState = IDLE;
            end else if (Start) begin
               // Starting with nothing on the clock expires straight away.
               if (CountIsZero) begin
                  nextState = EXPIRED;
                  nextDone  = 1'b1;
               end else begin
                  nextState = RUN;
               end
            end
         end
         RUN: begin
            // Load is ignored while running; the remaining commands still apply.
            if (Stop) begin
               nextState = PAUSE;
            end else if (Tick && !CountIsZero) begin
               DecEn = 1'b1;
               if (CountIsOne) begin
                  nextState = EXPIRED;
                  nextDone  = 1'b1;
               end
            end
         end
         PAUSE: begin
            if (Load) begin
               LoadEn    = 1'b1;
               nextState = IDLE;
            end else if (!Stop && Start) begin
               nextState = RUN;
            end
         end
         EXPIRED: begin
            // Start, Stop and Tick have no meaning here and never block Ack.
            if (Load) begin
               LoadEn    = 1'b1;
               nextState = IDLE;
            end else if (Ack) begin
               nextState = IDLE;
            end
         end
      endcase
   end

   // State register plus registered status flags derived from the next state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state   <= IDLE;
         Running <= 1'b0;
         Expired <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state   <= nextState;
         Running <= (nextState == RUN);
         Expired <= (nextState == EXPIRED);
         Done    <= nextDone;
      end
   end

endmodule

// File: rtl/count_down_timer.sv
// Programmable down-counter fed by periodic tick pulses. Holds the count
// register, saturates load values to MAX_COUNT and supplies the zero/one
// detects that the control FSM uses to decide expiry.
module count_down_timer
   import count_down_timer_pkg::*;
#(
   parameter int WIDTH     = DefaultWidth,
   parameter int MAX_COUNT = DefaultMaxCount
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             Tick,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadValue,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Ack,
   output logic [WIDTH-1:0] CountOut,
   output logic             Running,
   output logic             Expired,
   output logic             Done
);

   localparam logic [WIDTH-1:0] MaxCountW = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] loadSat;
   logic             countIsOne;
   logic             countIsZero;
   logic             decEn;
   logic             loadEn;

   assign loadSat     = (LoadValue > MaxCountW) ? MaxCountW : LoadValue;
   assign countIsOne  = (CountOut == WIDTH'(1));
   assign countIsZero = (CountOut == '0);

   timer_ctrl_fsm ctrl (
      .clk         (clk),
      .rst         (rst),
      .Load        (Load),
      .Start       (Start),
      .Stop        (Stop),
      .Ack         (Ack),
      .Tick        (Tick),
      .CountIsOne  (countIsOne),
      .CountIsZero (countIsZero),
      .DecEn       (decEn),
      .LoadEn      (loadEn),
      .Running     (Running),
      .Expired     (Expired),
      .Done        (Done)
   );

   // Count register: load the saturated value or step down by one on request.
   always_ff @(posedge clk) begin
      if (rst) begin
         CountOut <= '0;
      end else if (loadEn) begin
         CountOut <= loadSat;
      end else if (decEn) begin
         CountOut <= CountOut - 1'b1;
      end
   end

endmodule

// File: tb/tb_count_down_timer.sv
// Directed self-checking bench for count_down_timer. Status is compared as the
// packed vector {CountOut, Running, Expired, Done} one cycle after each stimulus
// edge. A small count-to-100 prescaler model supplies ticks for integration.
module tb_count_down_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic       tbTick;
   logic       Load;
   logic [6:0] LoadValue;
   logic       Start;
   logic       Stop;
   logic       Ack;
   logic [6:0] CountOut;
   logic       Running;
   logic       Expired;
   logic       Done;

   logic       usePre;
   logic [6:0] preCount;
   logic       TimeOut;
   logic       dutTick;
   logic [9:0] status;
   logic [9:0] want;
   int         totalChecks = 0;
   int         badChecks   = 0;

   assign TimeOut = (preCount == 7'd99);
   assign dutTick = tbTick | (usePre & TimeOut);
   assign status  = {CountOut, Running, Expired, Done};

   count_down_timer #(.WIDTH(7), .MAX_COUNT(99)) dut (
      .clk       (clk),
      .rst       (rst),
      .Tick      (dutTick),
      .Load      (Load),
      .LoadValue (LoadValue),
      .Start     (Start),
      .Stop      (Stop),
      .Ack       (Ack),
      .CountOut  (CountOut),
      .Running   (Running),
      .Expired   (Expired),
      .Done      (Done)
   );

   always #5 clk = ~clk;

   // Free-running count-to-100 prescaler model; TimeOut is high one cycle in 100.
   always_ff @(posedge clk) begin
      if (rst) preCount <= '0;
      else     preCount <= (preCount == 7'd99) ? 7'd0 : preCount + 7'd1;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one cycle of commands, then return all commands low.
   task automatic pulse(input logic ld, input logic st, input logic sp,
                        input logic ak, input logic tk, input logic [6:0] val);
      Load = ld; Start = st; Stop = sp; Ack = ak; tbTick = tk; LoadValue = val;
      step(1);
      Load = 1'b0; Start = 1'b0; Stop = 1'b0; Ack = 1'b0; tbTick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(2);
      want = {7'd0, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL reset_init got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      rst = 1'b0;
      pulse(1, 0, 0, 0, 0, 7'd9);
      pulse(0, 1, 0, 0, 0, 7'd0);
      pulse(0, 0, 0, 0, 1, 7'd0);
      want = {7'd8, 3'b100}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL reset_pre got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      // Reset mid-run with competing commands asserted: reset must win.
      rst = 1'b1; Load = 1'b1; LoadValue = 7'd5; Start = 1'b1; tbTick = 1'b1;
      step(1);
      want = {7'd0, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL reset_edge1 got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      step(1);
      totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL reset_edge2 got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      rst = 1'b0; Load = 1'b0; Start = 1'b0; tbTick = 1'b0;
      step(1);
      totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL reset_release got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
   endtask

   task automatic test_basic();
      pulse(1, 0, 0, 0, 0, 7'd5);
      want = {7'd5, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL basic_load got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(0, 1, 0, 0, 0, 7'd0);
      want = {7'd5, 3'b100}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL basic_start got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      for (int i = 1; i <= 5; i++) begin
         step(99);
         pulse(0, 0, 0, 0, 1, 7'd0);
         want = (i < 5) ? {7'(5 - i), 3'b100} : {7'd0, 3'b011};
         totalChecks++;
         if (status !== want) begin badChecks++;
            $display("FAIL basic_tick%0d got cnt=%0d red=%b want cnt=%0d red=%b", i, status[9:3], status[2:0], want[9:3], want[2:0]); end
      end
      step(1);
      want = {7'd0, 3'b010}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL basic_done_clear got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      step(50);
      totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL basic_sticky got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(0, 0, 0, 1, 0, 7'd0);
      want = {7'd0, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL basic_ack got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
   endtask

   task automatic test_saturation();
      pulse(1, 0, 0, 0, 0, 7'd120);
      want = {7'd99, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL sat_120 got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(1, 0, 0, 0, 0, 7'd98);
      want = {7'd98, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL sat_98 got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(1, 0, 0, 0, 0, 7'd100);
      want = {7'd99, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL sat_100 got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(1, 0, 0, 0, 0, 7'd0);
      want = {7'd0, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL sat_load0 got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(0, 1, 0, 0, 0, 7'd0);
      want = {7'd0, 3'b011}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL sat_start0 got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      step(1);
      want = {7'd0, 3'b010}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL sat_done_clear got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(0, 0, 0, 1, 0, 7'd0);
   endtask

   task automatic test_pause();
      pulse(1, 0, 0, 0, 0, 7'd10);
      pulse(0, 1, 0, 0, 0, 7'd0);
      repeat (3) pulse(0, 0, 0, 0, 1, 7'd0);
      want = {7'd7, 3'b100}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL pause_three got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(0, 0, 1, 0, 1, 7'd0);
      want = {7'd7, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL pause_stop_tick got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      repeat (5) pulse(0, 0, 0, 0, 1, 7'd0);
      totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL pause_ticks got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(0, 1, 0, 0, 0, 7'd0);
      want = {7'd7, 3'b100}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL pause_resume got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      for (int i = 1; i <= 7; i++) begin
         pulse(0, 0, 0, 0, 1, 7'd0);
         want = (i < 7) ? {7'(7 - i), 3'b100} : {7'd0, 3'b011};
         totalChecks++;
         if (status !== want) begin badChecks++;
            $display("FAIL pause_tick%0d got cnt=%0d red=%b want cnt=%0d red=%b", i, status[9:3], status[2:0], want[9:3], want[2:0]); end
      end
      pulse(0, 0, 0, 1, 0, 7'd0);
   endtask

   task automatic test_ignored();
      pulse(1, 0, 0, 0, 0, 7'd9);
      pulse(0, 1, 0, 0, 0, 7'd0);
      pulse(1, 0, 0, 0, 0, 7'd50);
      want = {7'd9, 3'b100}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL ign_load_run got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      tbTick = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         want = {7'(9 - i), 3'b100}; totalChecks++;
         if (status !== want) begin badChecks++;
            $display("FAIL ign_held%0d got cnt=%0d red=%b want cnt=%0d red=%b", i, status[9:3], status[2:0], want[9:3], want[2:0]); end
      end
      tbTick = 1'b0;
      pulse(0, 0, 1, 0, 0, 7'd0);
      pulse(1, 0, 0, 0, 0, 7'd1);
      pulse(0, 1, 0, 0, 0, 7'd0);
      pulse(0, 0, 0, 0, 1, 7'd0);
      want = {7'd0, 3'b011}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL ign_expire1 got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      Start = 1'b1; Stop = 1'b1; tbTick = 1'b1;
      step(2);
      Start = 1'b0; Stop = 1'b0; tbTick = 1'b0;
      want = {7'd0, 3'b010}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL ign_expired got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(1, 0, 0, 0, 0, 7'd3);
      want = {7'd3, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL ign_load_exp got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(0, 1, 0, 0, 0, 7'd0);
      want = {7'd3, 3'b100}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL ign_restart got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(0, 0, 1, 0, 0, 7'd0);
   endtask

   task automatic test_integration();
      int cycles;
      pulse(1, 0, 0, 0, 0, 7'd20);
      want = {7'd20, 3'b000}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL integ_load got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      usePre = 1'b1;
      pulse(0, 1, 0, 0, 0, 7'd0);
      cycles = 0;
      while (!Done && cycles < 2300) begin
         step(1);
         cycles++;
      end
      totalChecks++;
      if (!Done || cycles < 1900 || cycles > 2100) begin badChecks++;
         $display("FAIL integ_latency got done=%b after %0d clocks want done=1 within 1900..2100", Done, cycles); end
      usePre = 1'b0;
      step(1);
      want = {7'd0, 3'b010}; totalChecks++;
      if (status !== want) begin badChecks++;
         $display("FAIL integ_after got cnt=%0d red=%b want cnt=%0d red=%b", status[9:3], status[2:0], want[9:3], want[2:0]); end
      pulse(0, 0, 0, 1, 0, 7'd0);
   endtask

   initial begin
      rst = 1'b1; tbTick = 1'b0; Load = 1'b0; LoadValue = '0;
      Start = 1'b0; Stop = 1'b0; Ack = 1'b0; usePre = 1'b0;
      test_reset();
      test_basic();
      test_saturation();
      test_pause();
      test_ignored();
      test_integration();
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
